// File: rtl/add_sub_ser.sv
// Nibble-serial two's complement adder/subtractor with accumulator, sticky overflow
// and valid/ready handshakes; one 4-bit slice is resolved per clock, LSB first.
module add_sub_ser #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    input  logic             CLR,
    output logic [WIDTH-1:0] RES,
    output logic             CO,
    output logic             OVF,
    output logic             ZERO,
    output logic             NEG,
    output logic [WIDTH-1:0] ACC,
    output logic             STKY
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             acc_op_reg;
    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] part_reg;
    logic [WIDTH-1:0] res_reg;
    logic             co_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             stky_reg;

    logic [4:0]       sum;
    logic             c_msb;
    logic             ovf_f;
    logic [WIDTH-1:0] nxt_part;
    logic [WIDTH-1:0] res_final;

    // Operands shift right one nibble per cycle, so the active slice is always bits [3:0].
    assign sum = {1'b0, x_reg[3:0]} + {1'b0, y_reg[3:0]} + {4'd0, carry_reg};

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign c_msb = sum[3] ^ x_reg[3] ^ y_reg[3];
    assign ovf_f = c_msb ^ sum[4];

    // Result slices enter at the top and shift down; after N slices the word is aligned.
    assign nxt_part = WIDTH'({sum[3:0], part_reg} >> 4);

    // On overflow the raw MSB is the inverse of the true sign.
    assign res_final = ((SAT != 0) && ovf_f) ? (nxt_part[WIDTH-1] ? SMAX : SMIN) : nxt_part;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            acc_op_reg <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            part_reg   <= '0;
            res_reg    <= '0;
            co_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            zero_reg   <= 1'b0;
            neg_reg    <= 1'b0;
            acc_reg    <= '0;
            stky_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (IN_VALID) begin
                        x_reg      <= OP[1] ? acc_reg : A;
                        y_reg      <= (OP[1] ? A : B) ^ {WIDTH{OP[0]}};
                        carry_reg  <= OP[0];
                        acc_op_reg <= OP[1];
                        cnt_reg    <= '0;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    carry_reg <= sum[4];
                    part_reg  <= nxt_part;
                    x_reg     <= x_reg >> 4;
                    y_reg     <= y_reg >> 4;
                    if (cnt_reg == LAST) begin
                        state_reg <= DONE;
                        res_reg   <= res_final;
                        co_reg    <= sum[4];
                        ovf_reg   <= ovf_f;
                        zero_reg  <= (res_final == '0);
                        neg_reg   <= res_final[WIDTH-1];
                        if (acc_op_reg) begin
                            acc_reg <= res_final;
                        end
                        if (ovf_f) begin
                            stky_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Clear wins over a coincident accumulator or sticky update.
            if (CLR) begin
                acc_reg  <= '0;
                stky_reg <= 1'b0;
            end
        end
    end

    assign IN_READY  = (state_reg == IDLE);
    assign OUT_VALID = (state_reg == DONE);
    assign RES       = res_reg;
    assign CO        = co_reg;
    assign OVF       = ovf_reg;
    assign ZERO      = zero_reg;
    assign NEG       = neg_reg;
    assign ACC       = acc_reg;
    assign STKY      = stky_reg;

endmodule

// File: doc/add_sub_ser.md
ADD_SUB_SER -- requirements
Module: add_sub_ser

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL provide parameter SAT, default 0; 0 = wrap on overflow, 1 = saturate to signed max/min.
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide ports A, B  input  WIDTH  two's complement operands.
REQ-006 SHALL provide port OP  input  2  operation: 00 RES=A+B, 01 RES=A-B, 10 ACC=ACC+A, 11 ACC=ACC-A.
REQ-007 SHALL provide ports IN_VALID input 1 and IN_READY output 1, the request handshake.
REQ-008 SHALL provide ports OUT_VALID output 1 and OUT_READY input 1, the result handshake.
REQ-009 SHALL provide port CLR  input  1  synchronous clear of the accumulator and the sticky flag.
REQ-010 SHALL provide ports RES output WIDTH, CO output 1, OVF output 1, ZERO output 1 and NEG output 1; these carry the result and its flags.
REQ-011 SHALL provide ports ACC  output  WIDTH  accumulator value, and STKY  output  1  sticky overflow flag.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE; IN_READY=1 only in IDLE, and OUT_VALID=1 only in DONE.
REQ-013 In IDLE, IN_VALID=1 SHALL capture A, B and OP, clear the slice counter, load the carry with OP[0], and move to CALC.
REQ-014 Operand X SHALL be ACC when OP[1]=1 and A otherwise; operand Y SHALL be A when OP[1]=1 and B otherwise; for subtract, Y SHALL be bitwise inverted and the carry-in SHALL be 1.
REQ-015 CALC SHALL add one 4-bit slice per cycle, LSB slice first, using a registered ripple carry between slices.
REQ-016 After slice N-1, where N=WIDTH/4, the block SHALL enter DONE; OUT_VALID SHALL rise exactly N rising edges after the accepting edge.
REQ-017 CO SHALL be the carry out of the MSB; OVF SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-018 When SAT=1 and OVF=1, RES SHALL be 0111..1 if the sign of the true result is positive, else 1000..0; CO and OVF SHALL still report the raw result.
REQ-019 ZERO SHALL be set when RES is all zeros, and NEG SHALL equal RES[WIDTH-1], both evaluated on the final RES after any saturation.
REQ-020 For OP[1]=1, ACC SHALL load the final RES on the edge that enters DONE; ACC SHALL be unchanged for OP[1]=0.
REQ-021 STKY SHALL set on the edge entering DONE when OVF=1 and SHALL hold until CLR or reset.
REQ-022 DONE SHALL hold RES, CO, OVF, ZERO and NEG stable until OUT_READY=1, then return to IDLE on that edge.
REQ-023 IN_VALID SHALL be ignored outside IDLE, and a new request SHALL NOT be accepted on the same edge as DONE->IDLE.
REQ-024 CLR SHALL be honoured in any state; if CLR coincides with an ACC write, CLR SHALL take precedence and ACC SHALL become 0.
REQ-025 CLR SHALL NOT alter FSM state, RES or its flags.

Reset
REQ-026 nRST=0 SHALL immediately force state IDLE, with RES, ACC, CO, OVF, ZERO, NEG, STKY, OUT_VALID and the slice counter all 0.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no ACC or STKY update.
REQ-028 IN_READY SHALL read 1 while reset is held and the first cycle after release.

Verification (WIDTH=8 unless stated)
REQ-029 Test ADD with A=0x7F, B=0x01, SAT=0 -> RES=0x80, CO=0, OVF=1, NEG=1, STKY=1.
REQ-030 Test SUB with A=0x80, B=0x01 -> RES=0x7F, CO=1, OVF=1 for SAT=0, and RES=0x80 for SAT=1.
REQ-031 Test the accumulator: CLR, then OP=10 with A=0x05, then OP=11 with A=0x07 -> ACC=0x05, then ACC=0xFE, CO=0, NEG=1, OVF=0.
REQ-032 Test latency: OUT_VALID rises exactly 2 edges after acceptance for WIDTH=8 and exactly 4 edges for WIDTH=16; exhaustive 4-bit A/B sweep for WIDTH=4 matches the reference model.
REQ-033 Test back-pressure: with OUT_READY=0 for 5 cycles, RES and flags are stable and IN_VALID pulses are ignored; OUT_READY=1 -> IDLE on the next edge.
REQ-034 Test reset mid-CALC of ACC+=0x7F with ACC=0x01: all outputs go to 0 asynchronously, and ACC=0x00 and STKY=0 after release.
